mult_div_unit: RTL and testbench

Iterative 32-bit multiply/divide unit beside the multicycle core's ALU. Operands come from the A and B operand registers, and results go to the HI/LO registers that MFHI/MFLO write back through the register-file write mux. The Control FSM starts an operation and holds the instruction in a wait state while `busy` is high. HI/LO are held inside this block.

---
 rtl/mdu_pkg.sv | 29 ++
 rtl/mult_div_unit_if.sv | 29 ++
 rtl/mdu_iter_core.sv | 62 ++++++
 rtl/mult_div_unit.sv | 154 +++++++++++++++
 tb/tb_mult_div_unit.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small decode helpers.
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mduOp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        FIX  = 2'b11
    } mduState_e;

    function automatic logic isSignedOp(input mduOp_e op);
        return (op == MDU_MULT) || (op == MDU_DIV);
    endfunction

    function automatic logic isDivOp(input mduOp_e op);
        return op[1];
    endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Control/data bundle between the Control FSM side and the multiply/divide unit.
interface mult_div_unit_if
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) ();
    logic             start;
    mduOp_e           op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, hi_we, lo_we, wdata,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b, hi_we, lo_we, wdata,
        output busy, done, div_by_zero, hi, lo
    );
endinterface

// File: rtl/mdu_iter_core.sv
// Per-cycle datapath of the unit: accumulator / partial remainder, operand
// shift register and a single shared adder-subtractor. Works on magnitudes;
// sign handling lives in the top level.
module mdu_iter_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             res,
    input  logic             load,
    input  logic             step,
    input  logic             isDiv,
    input  logic [WIDTH-1:0] operand,   // multiplicand or divisor magnitude
    input  logic [WIDTH-1:0] shiftIn,   // multiplier or dividend magnitude
    output logic [WIDTH-1:0] accOut,    // product high half or remainder
    output logic [WIDTH-1:0] shiftOut   // product low half or quotient
);
    logic [WIDTH-1:0] accReg, shiftReg, operandReg;
    logic [WIDTH:0]   addA, addB;
    logic [WIDTH+1:0] sum;
    logic             divFits;

    // Shared adder: shift-add for multiply, trial subtract for divide.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        addA = {1'b0, accReg};
        addB = '0;
        if (isDiv) begin
            addA = {accReg, shiftReg[WIDTH-1]};
            addB = ~{1'b0, operandReg};
        end else if (shiftReg[0]) begin
            addB = {1'b0, operandReg};
        end
        sum     = {1'b0, addA} + {1'b0, addB} + {{(WIDTH+1){1'b0}}, isDiv};
        // Carry out of the trial subtract means the shifted remainder >= divisor.
        divFits = sum[WIDTH+1];
    end

    // Datapath registers: load magnitudes, then advance one bit per step.
    always_ff @(posedge clk or negedge res) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!res) begin
            accReg     <= '0;
            shiftReg   <= '0;
            operandReg <= '0;
        end else if (load) begin
            accReg     <= '0;
            shiftReg   <= shiftIn;
            operandReg <= operand;
        end else if (step) begin
            if (isDiv) begin
                accReg   <= divFits ? sum[WIDTH-1:0] : addA[WIDTH-1:0];
                shiftReg <= {shiftReg[WIDTH-2:0], divFits};
            end else begin
                accReg   <= sum[WIDTH:1];
                shiftReg <= {sum[0], shiftReg[WIDTH-1:1]};
            end
        end
    end

    assign accOut   = accReg;
    assign shiftOut = shiftReg;
endmodule

// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit with HI/LO registers and MTHI/MTLO writes.
// FSM: IDLE -> PREP -> ITER (WIDTH cycles) -> FIX -> IDLE.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic           clk,
    input  logic           res,
    mult_div_unit_if.slave mdu
);
    localparam int CW = $clog2(WIDTH);

    mduState_e          state, nextState;
    mduOp_e             opReg;
    logic [WIDTH-1:0]   aReg, bReg, aMag, bMag;
    logic [WIDTH-1:0]   coreAcc, coreShift, fixHi, fixLo, hiReg, loReg;
    logic [2*WIDTH-1:0] product;
    logic [CW-1:0]      count;
    logic               aNeg, bNeg, negLo, negHi, bZero, divOp;
    logic               acceptStart, loadCore, stepCore, writeResult;
    logic               busyReg, doneReg, dbzReg;

    assign divOp = isDivOp(opReg);
    assign bZero = (bReg == '0);

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) state <= IDLE;
        else      state <= nextState;
    end

    // Next-state logic; ITER leaves once the counter has run down.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (mdu.start) nextState = PREP;
            PREP:    nextState = ITER;
            ITER:    if (count == '0) nextState = FIX;
            FIX:     nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Per-state control strobes.
    always_comb begin
        acceptStart = (state == IDLE) && mdu.start;
        loadCore    = (state == PREP);
        stepCore    = (state == ITER);
        writeResult = (state == FIX);
    end

    // Capture op and operands when a start is accepted.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            opReg <= MDU_MULT;
            aReg  <= '0;
            bReg  <= '0;
        end else if (acceptStart) begin
            opReg <= mdu.op;
            aReg  <= mdu.a;
            bReg  <= mdu.b;
        end
    end

    // Operand magnitudes for signed ops.
    always_comb begin
        aNeg = isSignedOp(opReg) && aReg[WIDTH-1];
        bNeg = isSignedOp(opReg) && bReg[WIDTH-1];
        aMag = aNeg ? -aReg : aReg;
        bMag = bNeg ? -bReg : bReg;
    end

    // Result signs and iteration counter, set up in PREP.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            negLo <= 1'b0;
            negHi <= 1'b0;
            count <= '0;
        end else if (loadCore) begin
            negLo <= aNeg ^ bNeg;
            negHi <= aNeg;
            count <= CW'(WIDTH - 1);
        end else if (stepCore) begin
            count <= count - 1'b1;
        end
    end

    mdu_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk     (clk),
        .res     (res),
        .load    (loadCore),
        .step    (stepCore),
        .isDiv   (divOp),
        .operand (divOp ? bMag : aMag),
        .shiftIn (divOp ? aMag : bMag),
        .accOut  (coreAcc),
        .shiftOut(coreShift)
    );

    // Sign fix-up and divide-by-zero override of the raw core result.
    always_comb begin
        product = {coreAcc, coreShift};
        fixHi   = coreAcc;
        fixLo   = coreShift;
        if (divOp) begin
            if (bZero) begin
                fixHi = aReg;
                fixLo = '1;
            end else begin
                fixHi = negHi ? -coreAcc : coreAcc;
                fixLo = negLo ? -coreShift : coreShift;
            end
        end else begin
            if (negLo) product = -{coreAcc, coreShift};
            fixHi = product[2*WIDTH-1:WIDTH];
            fixLo = product[WIDTH-1:0];
        end
    end

    // HI/LO: result write at completion, MTHI/MTLO only while idle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            hiReg <= '0;
            loReg <= '0;
        end else if (writeResult) begin
            hiReg <= fixHi;
            loReg <= fixLo;
        end else if (state == IDLE) begin
            if (mdu.hi_we) hiReg <= mdu.wdata;
            if (mdu.lo_we) loReg <= mdu.wdata;
        end
    end

    // Registered status outputs.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            busyReg <= 1'b0;
            doneReg <= 1'b0;
            dbzReg  <= 1'b0;
        end else begin
            busyReg <= (nextState != IDLE);
            doneReg <= writeResult;
            if (acceptStart)      dbzReg <= 1'b0;
            else if (writeResult) dbzReg <= divOp && bZero;
        end
    end

    assign mdu.busy        = busyReg;
    assign mdu.done        = doneReg;
    assign mdu.div_by_zero = dbzReg;
    assign mdu.hi          = hiReg;
    assign mdu.lo          = loReg;
endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
    import mdu_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } expect_t;

    logic    clk = 1'b0;
    logic    res;
    int      checks = 0;
    int      failures = 0;
    expect_t sb[$];

    mult_div_unit_if #(.WIDTH(32)) mdu ();

    mult_div_unit #(.WIDTH(32)) dut (
        .clk(clk),
        .res(res),
        .mdu(mdu)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge; returns at the negedge of the done cycle.
    // disturb: 0 none, 1 start pulse mid-op, 2 hi_we/lo_we pulse mid-op.
    task automatic doOp(input string tag, input mduOp_e op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] expHi, input logic [31:0] expLo, input logic expDbz,
                        input int disturb, input int disturbAt, input logic weWithStart);
        expect_t e;
        int      cyc;
        mdu.start = 1'b1;
        mdu.op    = op;
        mdu.a     = a;
        mdu.b     = b;
        if (weWithStart) begin
            mdu.hi_we = 1'b1;
            mdu.lo_we = 1'b1;
            mdu.wdata = 32'hA5A5_5A5A;
        end
        sb.push_back('{tag, expHi, expLo, expDbz});
        @(posedge clk);
        @(negedge clk);
        mdu.start = 1'b0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        check({tag, "_busy_after_start"}, 64'(mdu.busy), 64'd1);
        check({tag, "_done_low_after_start"}, 64'(mdu.done), 64'd0);
        check({tag, "_dbz_cleared"}, 64'(mdu.div_by_zero), 64'd0);
        if (weWithStart) begin
            check({tag, "_we_with_start_hi"}, 64'(mdu.hi), 64'hA5A5_5A5A);
            check({tag, "_we_with_start_lo"}, 64'(mdu.lo), 64'hA5A5_5A5A);
        end
        for (cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            @(negedge clk);
            mdu.start = 1'b0;
            mdu.hi_we = 1'b0;
            mdu.lo_we = 1'b0;
            if (mdu.done === 1'b1) break;
            if (cyc == disturbAt && disturb == 1) begin
                mdu.start = 1'b1;
                mdu.op    = MDU_DIVU;
                mdu.a     = 32'd1;
                mdu.b     = 32'd1;
            end
            if (cyc == disturbAt && disturb == 2) begin
                mdu.hi_we = 1'b1;
                mdu.lo_we = 1'b1;
                mdu.wdata = 32'hDEAD_BEEF;
            end
        end
        check({tag, "_latency"}, 64'(cyc), 64'd34);
        check({tag, "_busy_low_at_done"}, 64'(mdu.busy), 64'd0);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, "_hi"}, 64'(mdu.hi), 64'(e.hi));
            check({e.tag, "_lo"}, 64'(mdu.lo), 64'(e.lo));
            check({e.tag, "_dbz"}, 64'(mdu.div_by_zero), 64'(e.dbz));
        end
    endtask

    initial begin
        logic sawDone;
        mdu.start = 1'b0;
        mdu.op    = MDU_MULT;
        mdu.a     = '0;
        mdu.b     = '0;
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b0;
        mdu.wdata = '0;
        res       = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check("reset_busy", 64'(mdu.busy), 64'd0);
        check("reset_done", 64'(mdu.done), 64'd0);
        check("reset_dbz", 64'(mdu.div_by_zero), 64'd0);
        check("reset_hi", 64'(mdu.hi), 64'd0);
        check("reset_lo", 64'(mdu.lo), 64'd0);

        // Back-to-back operations: each start lands in the previous done cycle.
        doOp("mult_neg",     MDU_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 0, 0, 1'b0);
        doOp("multu_max",    MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 0, 0, 1'b0);
        doOp("div_neg",      MDU_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 0, 0, 1'b0);
        doOp("divu_100_7",   MDU_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0, 0, 0, 1'b0);
        doOp("divu_by_zero", MDU_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);
        doOp("mult_after_dz",MDU_MULT,  32'd5,         32'd6,         32'd0,         32'd30,        1'b0, 0, 0, 1'b0);
        doOp("div_overflow", MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0, 0, 0, 1'b0);
        doOp("mult_min_sq",  MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 0, 0, 1'b0);
        doOp("multu_midstart", MDU_MULTU, 32'h1234_5678, 32'h10,      32'h0000_0001, 32'h2345_6780, 1'b0, 1, 10, 1'b0);
        doOp("div_midwe",    MDU_DIV,   32'd1000,      32'hFFFF_FFFD, 32'd1,         32'hFFFF_FEB3, 1'b0, 2, 12, 1'b0);

        // MTHI/MTLO while idle, both together then LO alone.
        mdu.hi_we = 1'b1;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'hCAFE_F00D;
        @(posedge clk);
        @(negedge clk);
        mdu.hi_we = 1'b0;
        mdu.lo_we = 1'b1;
        mdu.wdata = 32'h1111_2222;
        check("mt_both_hi", 64'(mdu.hi), 64'hCAFE_F00D);
        check("mt_both_lo", 64'(mdu.lo), 64'hCAFE_F00D);
        @(posedge clk);
        @(negedge clk);
        mdu.lo_we = 1'b0;
        check("mtlo_only_lo", 64'(mdu.lo), 64'h1111_2222);
        check("mtlo_only_hi", 64'(mdu.hi), 64'hCAFE_F00D);

        doOp("divu_we_start", MDU_DIVU, 32'd9,         32'd3,         32'd0,         32'd3,         1'b0, 0, 0, 1'b1);
        doOp("div_by_zero_s", MDU_DIV,  32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 0, 0, 1'b0);

        // Reset in the middle of ITER: everything clears, no done follows.
        mdu.start = 1'b1;
        mdu.op    = MDU_MULT;
        mdu.a     = 32'd3;
        mdu.b     = 32'd3;
        @(posedge clk);
        @(negedge clk);
        mdu.start = 1'b0;
        repeat (11) @(negedge clk);
        check("pre_reset_busy", 64'(mdu.busy), 64'd1);
        #2 res = 1'b0;
        #1;
        check("midreset_busy", 64'(mdu.busy), 64'd0);
        check("midreset_hi", 64'(mdu.hi), 64'd0);
        check("midreset_lo", 64'(mdu.lo), 64'd0);
        check("midreset_dbz", 64'(mdu.div_by_zero), 64'd0);
        check("midreset_done", 64'(mdu.done), 64'd0);
        @(negedge clk);
        res = 1'b1;
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (mdu.done === 1'b1) sawDone = 1'b1;
        end
        check("midreset_no_done", 64'(sawDone), 64'd0);
        check("midreset_idle_busy", 64'(mdu.busy), 64'd0);
        check("midreset_hi_held", 64'(mdu.hi), 64'd0);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
